// File: rtl/picomips_pkg.sv
// Shared definitions for the input front end.
// Holds the debounce FSM state type and the default debounce length.
package picomips_pkg;

  localparam int unsigned DEBOUNCE_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    ACTIVE   = 2'd2,
    REL_DB   = 2'd3
  } fe_state_t;

endpackage

// File: rtl/input_frontend_if.sv
// Pushbutton/switch inputs and cpu-facing outputs of the input front end.
// The master side drives the raw inputs; the slave side (the front end)
// drives handshake, index and press_cnt.
interface input_frontend_if #(
  parameter int unsigned IDX_W = 8
);

  logic             btn_raw;
  logic [IDX_W-1:0] sw_raw;
  logic             handshake;
  logic [IDX_W-1:0] index;
  logic [7:0]       press_cnt;

  modport master (
    output btn_raw, sw_raw,
    input  handshake, index, press_cnt
  );

  modport slave (
    input  btn_raw, sw_raw,
    output handshake, index, press_cnt
  );

endinterface

// File: rtl/input_frontend_sync2.sv
// Two-flop synchronizer, parameterised width, async active-low reset.
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops to resolve metastability on asynchronous inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/input_frontend.sv
// Pushbutton debouncer and switch-index capture feeding the cpu handshake.
// Optional macro HS_PULSE_EN: handshake becomes a single-cycle pulse on each
// confirmed press instead of a level held until the confirmed release.
module input_frontend
  import picomips_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned IDX_W           = 8
) (
  input logic             clk,
  input logic             reset,
  input_frontend_if.slave fe
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             btn_s;
  logic [IDX_W-1:0] sw_s;

  fe_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             hs_q;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       pcnt_q;
  logic             cnt_last;

  sync2 #(.WIDTH(1)) u_sync_btn (
    .clk   (clk),
    .rst_n (reset),
    .d_i   (fe.btn_raw),
    .q_o   (btn_s)
  );

  sync2 #(.WIDTH(IDX_W)) u_sync_sw (
    .clk   (clk),
    .rst_n (reset),
    .d_i   (fe.sw_raw),
    .q_o   (sw_s)
  );

  // Debounce period is complete once cnt has seen DEBOUNCE_CYCLES samples.
  always_comb begin
    cnt_last = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
  end

  // Debounce FSM with registered handshake, index and press counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hs_q    <= 1'b0;
      idx_q   <= '0;
      pcnt_q  <= '0;
    end else begin
`ifdef HS_PULSE_EN
      // Pulse build: handshake defaults low and is raised for the single
      // cycle following the PRESS_DB -> ACTIVE transition below.
      hs_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (btn_s) begin
            state_q <= PRESS_DB;
            cnt_q   <= '0;
          end
        end
        PRESS_DB: begin
          if (!btn_s) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_last) begin
            state_q <= ACTIVE;
            idx_q   <= sw_s;
            pcnt_q  <= pcnt_q + 8'd1;
            hs_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ACTIVE: begin
          if (!btn_s) begin
            state_q <= REL_DB;
            cnt_q   <= '0;
          end
        end
        REL_DB: begin
          if (btn_s) begin
            state_q <= ACTIVE;
          end else if (cnt_last) begin
            state_q <= IDLE;
            hs_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign fe.handshake = hs_q;
  assign fe.index     = idx_q;
  assign fe.press_cnt = pcnt_q;

endmodule

// File: tb/tb_input_frontend.sv
// Scoreboard bench for input_frontend: stimulus pushes expected handshake
// edges (cycle, index, press_cnt); a negedge monitor pops and compares.
module tb_input_frontend;

  localparam int D = 4;

  typedef struct {
    int         cyc;
    logic [7:0] idx;
    logic [7:0] cnt;
  } rise_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  int         cyc = 0;
  int         total = 0;
  int         passed = 0;
  int         rises = 0;
  logic       prev_hs = 1'b0;
  logic [7:0] exp_cnt = 8'd0;
  rise_t      rq[$];
  int         fq[$];

`ifdef HS_PULSE_EN
  localparam int HS_HELD = 0;
`else
  localparam int HS_HELD = 1;
`endif

  input_frontend_if #(.IDX_W(8)) fe_if ();

  input_frontend #(.DEBOUNCE_CYCLES(D), .IDX_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .fe    (fe_if.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: compare every handshake edge against the scoreboard queues.
  always @(negedge clk) begin
    rise_t e;
    if (!reset) begin
      prev_hs = 1'b0;
    end else begin
      if (fe_if.handshake && !prev_hs) begin
        rises++;
        if (rq.size() == 0) begin
          total++;
          $display("FAIL unexpected_rise: got rise at cycle %0d expected none", cyc);
        end else begin
          e = rq.pop_front();
          chk("rise_cycle", cyc, e.cyc);
          chk("rise_index", int'(fe_if.index), int'(e.idx));
          chk("rise_press_cnt", int'(fe_if.press_cnt), int'(e.cnt));
        end
      end
      if (!fe_if.handshake && prev_hs) begin
        if (fq.size() == 0) begin
          total++;
          $display("FAIL unexpected_fall: got fall at cycle %0d expected none", cyc);
        end else begin
          chk("fall_cycle", cyc, fq.pop_front());
        end
      end
      prev_hs = fe_if.handshake;
    end
  end

  task automatic press(input logic [7:0] sw);
    fe_if.sw_raw = sw;
    repeat (3) @(negedge clk);
    exp_cnt = exp_cnt + 8'd1;
    fe_if.btn_raw = 1'b1;
    rq.push_back('{cyc + D + 3, sw, exp_cnt});
`ifdef HS_PULSE_EN
    fq.push_back(cyc + D + 4);
`endif
    repeat (D + 6) @(negedge clk);
  endtask

  task automatic release_btn();
    fe_if.btn_raw = 1'b0;
`ifndef HS_PULSE_EN
    fq.push_back(cyc + D + 3);
`endif
    repeat (D + 6) @(negedge clk);
  endtask

  initial begin
    int r0;
    fe_if.btn_raw = 1'b0;
    fe_if.sw_raw  = 8'd0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_handshake", int'(fe_if.handshake), 0);
    chk("reset_index", int'(fe_if.index), 0);
    chk("reset_press_cnt", int'(fe_if.press_cnt), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Short bounces never complete the press debounce.
    fe_if.btn_raw = 1'b1; repeat (2) @(negedge clk);
    fe_if.btn_raw = 1'b0; repeat (2) @(negedge clk);
    fe_if.btn_raw = 1'b1; repeat (2) @(negedge clk);
    fe_if.btn_raw = 1'b0; repeat (8) @(negedge clk);
    chk("bounce_handshake", int'(fe_if.handshake), 0);
    chk("bounce_press_cnt", int'(fe_if.press_cnt), 0);

    // Clean press, then switch change must not disturb index.
    press(8'd2);
    fe_if.sw_raw = 8'd9;
    repeat (6) @(negedge clk);
    chk("index_hold", int'(fe_if.index), 2);
    release_btn();
    press(8'd9);

    // Release bounce: back to ACTIVE with no output change.
    fe_if.btn_raw = 1'b0; repeat (2) @(negedge clk);
    fe_if.btn_raw = 1'b1; repeat (10) @(negedge clk);
    chk("relbounce_handshake", int'(fe_if.handshake), HS_HELD);
    chk("relbounce_press_cnt", int'(fe_if.press_cnt), 2);
    chk("relbounce_index", int'(fe_if.index), 9);
    release_btn();

    // Long hold yields exactly one rising edge.
    r0 = rises;
    press(8'd5);
    repeat (40) @(negedge clk);
    chk("long_hold_rises", rises - r0, 1);
    chk("long_hold_handshake", int'(fe_if.handshake), HS_HELD);

    // Reset mid-press with button held: full debounce again after release.
    #2 reset = 1'b0;
    #1;
    chk("midreset_handshake", int'(fe_if.handshake), 0);
    chk("midreset_index", int'(fe_if.index), 0);
    chk("midreset_press_cnt", int'(fe_if.press_cnt), 0);
    fq.delete();
    repeat (2) @(negedge clk);
    exp_cnt = 8'd1;
    reset = 1'b1;
    rq.push_back('{cyc + D + 3, 8'd5, 8'd1});
`ifdef HS_PULSE_EN
    fq.push_back(cyc + D + 4);
`endif
    repeat (D + 6) @(negedge clk);
    release_btn();

    // 256 presses from reset wrap press_cnt back to zero.
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_cnt = 8'd0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      press(8'(i));
      release_btn();
    end
    chk("wrap_press_cnt", int'(fe_if.press_cnt), 0);
    chk("wrap_index", int'(fe_if.index), 255);

    repeat (4) @(negedge clk);
    chk("pending_rises", rq.size(), 0);
    chk("pending_falls", fq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/input_frontend.md
INPUT_FRONTEND -- requirements
Module: input_frontend

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, number of consecutive stable synchronized samples that confirm a press or release; legal range 1..255.
REQ-002 Parameter IDX_W, default 8, width of the switch index bus.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-005 btn_raw  input  1  raw asynchronous pushbutton, 1 = pressed.
REQ-006 sw_raw  input  IDX_W  raw asynchronous slide-switch index value.
REQ-007 handshake  output  1  drives the cpu handshake input.
REQ-008 index  output  IDX_W  drives the cpu index input; stable whenever handshake is 1.
REQ-009 press_cnt  output  8  count of confirmed presses, for debug.

Function
REQ-010 btn_raw and every bit of sw_raw SHALL pass through a two-flop synchronizer (btn_s, sw_s) before any other use.
REQ-011 The FSM SHALL have exactly four states: IDLE, PRESS_DB, ACTIVE, REL_DB. The debounce counter cnt SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide.
REQ-012 IDLE: btn_s=1 -> PRESS_DB with cnt=0; otherwise stay in IDLE.
REQ-013 PRESS_DB: btn_s=0 -> IDLE with cnt=0 (bounce). btn_s=1 and cnt==DEBOUNCE_CYCLES-1 -> ACTIVE. Otherwise cnt increments.
REQ-014 On entry to ACTIVE: index SHALL load sw_s, press_cnt SHALL increment (wrapping from 255 to 0), and handshake SHALL be set.
REQ-015 ACTIVE: btn_s=0 -> REL_DB with cnt=0; otherwise stay in ACTIVE.
REQ-016 REL_DB: btn_s=1 -> ACTIVE (bounce) with no reload of index, no increment of press_cnt and no change to handshake. btn_s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE with handshake cleared. Otherwise cnt increments.
REQ-017 Press latency: handshake SHALL rise exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples btn_raw=1, provided btn_raw stays high.
REQ-018 Release latency: handshake SHALL fall after the same DEBOUNCE_CYCLES+3 edges, measured from the first edge that samples btn_raw=0.
REQ-019 index SHALL change only on entry to ACTIVE from PRESS_DB; it holds its value through REL_DB, IDLE and subsequent sw_raw changes.
REQ-020 A btn_raw glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no change on any output.

Reset
REQ-021 While reset=0: state=IDLE, cnt=0, handshake=0, index=0, press_cnt=0, and all synchronizer flops=0.
REQ-022 Reset asserted mid-operation (any state) SHALL drop handshake to 0 asynchronously. After release, a button still held SHALL pass the full press debounce before handshake re-asserts.

Configuration
REQ-023 Macro HS_PULSE_EN.
- Defined: handshake is high for exactly one cycle on entry to ACTIVE from PRESS_DB, and 0 at all other times. A bounce from REL_DB back to ACTIVE produces no pulse. No new pulse occurs until the FSM has returned to IDLE.
- Undefined: level behaviour per REQ-014..REQ-018.
- All other outputs and the FSM are identical in both builds.

Structure
REQ-024 The shared package picomips_pkg SHALL hold the fe_state_t enum (IDLE, PRESS_DB, ACTIVE, REL_DB) and the constant DEBOUNCE_DEFAULT=4.
REQ-025 The single sub-module sync2 (parameterised width, two-flop, async active-low reset) SHALL be instantiated once for btn_raw and once for sw_raw.

Verification
REQ-026 Clean press, DEBOUNCE_CYCLES=4: sw_raw=8'd2, btn_raw rises and is held -> handshake=1 on edge 7 after the first sample, index=8'd2, press_cnt=1.
REQ-027 Bounce: btn_raw high for 2 cycles, low, high for 2 cycles, low -> handshake stays 0, press_cnt stays 0.
REQ-028 Index hold: after handshake=1, sw_raw changes to 8'd9 -> index stays 8'd2. Release, then a new press -> index=8'd9, press_cnt=2.
REQ-029 Release bounce: in ACTIVE, btn_raw low for 2 cycles then high -> handshake stays 1, press_cnt unchanged. A final clean release -> handshake falls 7 edges after the first low sample.
REQ-030 Reset mid-press: reset=0 while in ACTIVE -> handshake=0, index=0 and press_cnt=0 immediately. Reset released with btn_raw still high -> handshake rises 7 edges later.
REQ-031 HS_PULSE_EN build: btn_raw held high for 50 cycles -> handshake is exactly one 1-cycle pulse. 256 clean presses -> press_cnt wraps to 0.
